// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs,
// ALU controls and datapath mux selects.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Immediate logic ops reuse the R-type funct path through an equivalent funct.
    function automatic logic [5:0] imm_funct(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_funct = FN_AND;
            OP_ORI:  imm_funct = FN_OR;
            OP_SLTI: imm_funct = FN_SLT;
            default: imm_funct = FN_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_alu_decoder.sv
// Combinational ALU control decode from (alu_op, funct).
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ALU_OP_SUB: alu_ctrl_o = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct_i)
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath with mem_ready handshake.
// Define MC_CTRL_IMM_EXT_EN to also accept andi/ori/slti.
module multi_cycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctrl,
    output logic       instr_done,
    output logic       illegal_op
);

    logic [STATE_W-1:0] state_q, state_d;
    logic       mem_req_c, iord_c, mem_write_c, ir_write_c, pc_write_c, branch_c;
    logic       reg_write_c, reg_dst_c, mem_to_reg_c, alu_src_a_c, alu_en_c;
    logic       instr_done_c, illegal_op_c;
    logic [1:0] alu_src_b_c, pc_src_c, alu_op_c;
    logic [5:0] funct_sel_c;
    logic [2:0] alu_dec_c;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state and per-state control decode
    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_en_c     = 1'b0;
        instr_done_c = 1'b0;
        illegal_op_c = 1'b0;
        alu_src_b_c  = SRCB_B;
        pc_src_c     = PCSRC_ALU;
        alu_op_c     = ALU_OP_ADD;
        funct_sel_c  = funct;
        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                alu_en_c    = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_IMM_SH;
                alu_en_c    = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_IMM_EXT_EN
                    OP_ANDI, OP_ORI, OP_SLTI: state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal_op_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_en_c    = 1'b1;
                state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c   = 1'b1;
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_OP_FUNCT;
                alu_en_c    = 1'b1;
                state_d     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQEX: begin
                alu_src_a_c  = 1'b1;
                alu_op_c     = ALU_OP_SUB;
                alu_en_c     = 1'b1;
                pc_src_c     = PCSRC_ALUOUT;
                branch_c     = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_en_c    = 1'b1;
`ifdef MC_CTRL_IMM_EXT_EN
                if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_SLTI) begin
                    alu_op_c    = ALU_OP_FUNCT;
                    funct_sel_c = imm_funct(opcode);
                end
`endif
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JEX: begin
                pc_src_c     = PCSRC_JUMP;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op_c),
        .funct_i    (funct_sel_c),
        .alu_ctrl_o (alu_dec_c)
    );

    // Reset forces every control low so an aborted instruction writes nothing.
    assign mem_req    = ~reset & mem_req_c;
    assign iord       = ~reset & iord_c;
    assign mem_write  = ~reset & mem_write_c;
    assign ir_write   = ~reset & ir_write_c;
    assign pc_en      = ~reset & (pc_write_c | (branch_c & zero));
    assign reg_write  = ~reset & reg_write_c;
    assign reg_dst    = ~reset & reg_dst_c;
    assign mem_to_reg = ~reset & mem_to_reg_c;
    assign alu_src_a  = ~reset & alu_src_a_c;
    assign alu_src_b  = reset ? 2'b00 : alu_src_b_c;
    assign pc_src     = reset ? 2'b00 : pc_src_c;
    assign alu_ctrl   = (reset || !alu_en_c) ? 3'b000 : alu_dec_c;
    assign instr_done = ~reset & instr_done_c;
    assign illegal_op = ~reset & illegal_op_c;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed scenarios plus randomized
// instructions with random memory stalls, checked against a per-instruction model.
module tb_multi_cycle_control;

`ifdef MC_CTRL_IMM_EXT_EN
    localparam bit IMM_EXT = 1'b1;
`else
    localparam bit IMM_EXT = 1'b0;
`endif

    logic       clk, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;

    int checks = 0;
    int errors = 0;

    // Observations from one instruction
    int obs_cycles, obs_mreq, obs_rw, obs_mw, obs_irw, obs_pcen, obs_done, obs_ill;
    int obs_rw_cycle, obs_bad;
    bit obs_timeout;
    logic       obs_rw_dst, obs_rw_m2r, obs_pcen_ex;
    logic [2:0] obs_alu_ex;
    logic [1:0] obs_pcsrc_ex;

    multi_cycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instruction-level) ----------------
    function automatic bit is_imm_ext(input logic [5:0] op);
        return IMM_EXT && (op == 6'b001100 || op == 6'b001101 || op == 6'b001010);
    endfunction

    function automatic bit is_mem(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011;
    endfunction

    function automatic int base_cycles(input logic [5:0] op);
        if (op == 6'b100011) return 5;
        if (op == 6'b101011 || op == 6'b000000 || op == 6'b001000 || is_imm_ext(op)) return 4;
        if (op == 6'b000100 || op == 6'b000010) return 3;
        return 2;
    endfunction

    function automatic bit writes_reg(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b000000 || op == 6'b001000 || is_imm_ext(op);
    endfunction

    function automatic logic [2:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b101010: return 3'b111;
                default:   return 3'b010;
            endcase
        end
        if (op == 6'b000100) return 3'b110;
        if (is_imm_ext(op)) begin
            if (op == 6'b001100) return 3'b000;
            if (op == 6'b001101) return 3'b001;
            return 3'b111;
        end
        return 3'b010;
    endfunction

    // ---------------- stimulus driver ----------------
    // Runs one instruction from FETCH; sf = fetch stalls, sm = memory-phase stalls.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int sf, input int sm);
        int  cyc;
        bit  fin;
        cyc = 0; fin = 1'b0;
        obs_mreq = 0; obs_rw = 0; obs_mw = 0; obs_irw = 0; obs_pcen = 0; obs_done = 0;
        obs_ill = 0; obs_rw_cycle = -1; obs_bad = 0;
        obs_rw_dst = 1'b0; obs_rw_m2r = 1'b0; obs_pcen_ex = 1'b0;
        obs_alu_ex = 3'b000; obs_pcsrc_ex = 2'b00;
        opcode = op; funct = fn;
        while (!fin && cyc < 40) begin
            if (cyc < sf) mem_ready = 1'b0;
            else if (cyc == sf) mem_ready = 1'b1;
            else if (is_mem(op) && cyc >= sf + 3 && cyc < sf + 3 + sm) mem_ready = 1'b0;
            else if (is_mem(op) && cyc == sf + 3 + sm) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            zero = (cyc == sf + 2) ? z : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (mem_req) obs_mreq++;
            if (mem_write) obs_mw++;
            if (mem_write && (!iord || !mem_req)) obs_bad++;
            if (ir_write) obs_irw++;
            if (pc_en) obs_pcen++;
            if (instr_done) obs_done++;
            if (illegal_op) obs_ill++;
            if (reg_write) begin
                obs_rw++; obs_rw_cycle = cyc; obs_rw_dst = reg_dst; obs_rw_m2r = mem_to_reg;
            end
            if (cyc == sf + 2) begin
                obs_alu_ex = alu_ctrl; obs_pcen_ex = pc_en; obs_pcsrc_ex = pc_src;
            end
            if (instr_done || illegal_op) fin = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        obs_cycles  = cyc;
        obs_timeout = !fin;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b100011; funct = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, pc_src, alu_ctrl, instr_done, illegal_op} !== 18'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got nonzero outputs, expected all 0", i);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, ir_write, pc_en, iord} !== 4'b1110) begin
            errors++;
            $display("FAIL first_fetch: mem_req/ir_write/pc_en/iord = %b, expected 1110",
                     {mem_req, ir_write, pc_en, iord});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
        checks++;
        if (obs_cycles !== 5 || obs_timeout) begin
            errors++; $display("FAIL lw_cycles: got %0d, expected 5", obs_cycles);
        end
        checks++;
        if (obs_rw !== 1 || obs_rw_cycle !== 4 || obs_rw_m2r !== 1'b1 || obs_rw_dst !== 1'b0) begin
            errors++;
            $display("FAIL lw_writeback: count %0d cycle %0d m2r %b dst %b, expected 1 4 1 0",
                     obs_rw, obs_rw_cycle, obs_rw_m2r, obs_rw_dst);
        end
        checks++;
        if (obs_done !== 1 || obs_mw !== 0) begin
            errors++; $display("FAIL lw_done: done %0d memwrite %0d, expected 1 0", obs_done, obs_mw);
        end
    endtask

    task automatic test_sw_stall();
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 2);
        checks++;
        if (obs_mw !== 3 || obs_bad !== 0) begin
            errors++; $display("FAIL sw_mem_write: cycles %0d bad %0d, expected 3 0", obs_mw, obs_bad);
        end
        checks++;
        if (obs_cycles !== 6 || obs_done !== 1 || obs_rw !== 0) begin
            errors++;
            $display("FAIL sw_timing: cycles %0d done %0d rw %0d, expected 6 1 0",
                     obs_cycles, obs_done, obs_rw);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [2];
        logic [2:0] exp [2];
        fns[0] = 6'b100010; exp[0] = 3'b110;
        fns[1] = 6'b101010; exp[1] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            run_instr(6'b000000, fns[i], 1'b0, 0, 0);
            checks++;
            if (obs_alu_ex !== exp[i]) begin
                errors++; $display("FAIL rtype_alu funct %b: got %b, expected %b", fns[i], obs_alu_ex, exp[i]);
            end
            checks++;
            if (obs_rw !== 1 || obs_rw_dst !== 1'b1 || obs_rw_m2r !== 1'b0 || obs_cycles !== 4) begin
                errors++;
                $display("FAIL rtype_wb: rw %0d dst %b m2r %b cycles %0d, expected 1 1 0 4",
                         obs_rw, obs_rw_dst, obs_rw_m2r, obs_cycles);
            end
        end
    endtask

    task automatic test_beq();
        for (int i = 0; i < 2; i++) begin
            logic z;
            z = (i == 0);
            run_instr(6'b000100, 6'b000000, z, 0, 0);
            checks++;
            if (obs_pcen_ex !== z || obs_pcsrc_ex !== 2'b01) begin
                errors++;
                $display("FAIL beq_branch zero=%b: pc_en %b pc_src %b, expected %b 01",
                         z, obs_pcen_ex, obs_pcsrc_ex, z);
            end
            checks++;
            if (obs_cycles !== 3 || obs_pcen !== 1 + int'(z) || obs_alu_ex !== 3'b110) begin
                errors++;
                $display("FAIL beq_timing zero=%b: cycles %0d pc_en count %0d alu %b", z,
                         obs_cycles, obs_pcen, obs_alu_ex);
            end
        end
    endtask

    task automatic test_imm_ext();
        run_instr(6'b001101, 6'($urandom_range(0, 63)), 1'b0, 0, 0);
        if (IMM_EXT) begin
            checks++;
            if (obs_alu_ex !== 3'b001 || obs_rw !== 1 || obs_rw_cycle !== 3 || obs_ill !== 0) begin
                errors++;
                $display("FAIL ori_ext: alu %b rw %0d rw_cycle %0d ill %0d, expected 001 1 3 0",
                         obs_alu_ex, obs_rw, obs_rw_cycle, obs_ill);
            end
        end else begin
            checks++;
            if (obs_ill !== 1 || obs_cycles !== 2 || obs_rw !== 0 || obs_done !== 0) begin
                errors++;
                $display("FAIL ori_illegal: ill %0d cycles %0d rw %0d done %0d, expected 1 2 0 0",
                         obs_ill, obs_cycles, obs_rw, obs_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, iord, mem_write, reg_write, pc_en, ir_write} !== 6'd0) begin
            errors++; $display("FAIL reset_mid_outputs: writes/requests active during reset");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, iord, ir_write, reg_write} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_mid_refetch: mem_req/iord/ir_write/reg_write = %b, expected 1010",
                     {mem_req, iord, ir_write, reg_write});
        end
        @(posedge clk); #1;
        opcode = 6'b111111;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        logic [5:0] fns [5];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b001100, 6'b001101, 6'b001010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op, fn;
            logic       z;
            int         sf, sm, exp_cyc, exp_mreq, exp_pcen;
            bit         legal;
            op = (n % 7 == 6) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
            z  = 1'($urandom_range(0, 1));
            sf = $urandom_range(0, 2);
            sm = is_mem(op) ? $urandom_range(0, 3) : 0;
            run_instr(op, fn, z, sf, sm);
            legal    = base_cycles(op) > 2;
            exp_cyc  = base_cycles(op) + sf + sm;
            exp_mreq = 1 + sf + (is_mem(op) ? 1 + sm : 0);
            exp_pcen = 1 + int'(op == 6'b000010) + int'(op == 6'b000100 && z);
            checks++;
            if (obs_timeout || obs_cycles !== exp_cyc || obs_mreq !== exp_mreq) begin
                errors++;
                $display("FAIL rand_timing op %b sf %0d sm %0d: cycles %0d mem_req %0d, expected %0d %0d",
                         op, sf, sm, obs_cycles, obs_mreq, exp_cyc, exp_mreq);
            end
            checks++;
            if (obs_rw !== int'(writes_reg(op)) || obs_mw !== (op == 6'b101011 ? 1 + sm : 0) ||
                obs_irw !== 1 || obs_pcen !== exp_pcen || obs_bad !== 0) begin
                errors++;
                $display("FAIL rand_writes op %b: rw %0d mw %0d irw %0d pcen %0d bad %0d (pcen exp %0d)",
                         op, obs_rw, obs_mw, obs_irw, obs_pcen, obs_bad, exp_pcen);
            end
            checks++;
            if (obs_done !== int'(legal) || obs_ill !== int'(!legal)) begin
                errors++;
                $display("FAIL rand_done op %b: done %0d ill %0d, expected %0d %0d",
                         op, obs_done, obs_ill, int'(legal), int'(!legal));
            end
            if (legal && op != 6'b000010) begin
                checks++;
                if (obs_alu_ex !== exp_alu(op, fn)) begin
                    errors++;
                    $display("FAIL rand_alu op %b fn %b: got %b, expected %b",
                             op, fn, obs_alu_ex, exp_alu(op, fn));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_beq();
        test_imm_ext();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
